// File: rtl/cache_axi_ctl.sv
// Line-transfer responder: one 64-byte line per direction, moved as 8-beat AXI4 INCR bursts.
// Optional response checking is enabled by defining AXI_CTL_RESP_CHECK_EN.
module cache_axi_ctl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        rw_i,
    input  logic [63:0] addr_i,
    input  logic        fifo_wen_i,
    input  logic [63:0] fifo_data_i,
    input  logic        fifo_done_i,
    output logic        done_o,
    output logic [63:0] data_o,
    output logic [2:0]  beat_idx_o,
    output logic        err_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [63:0] araddr_o,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic        rvalid_i,
    output logic        rready_o,
    input  logic [63:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    output logic        awvalid_o,
    input  logic        awready_i,
    output logic [63:0] awaddr_o,
    output logic [7:0]  awlen_o,
    output logic [2:0]  awsize_o,
    output logic [1:0]  awburst_o,
    output logic        wvalid_o,
    input  logic        wready_i,
    output logic [63:0] wdata_o,
    output logic [7:0]  wstrb_o,
    output logic        wlast_o,
    input  logic        bvalid_i,
    output logic        bready_o,
    input  logic [1:0]  bresp_i
);

    typedef enum logic [2:0] {IDLE, AR, R, STREAM, AW, W, B, DONE} state_t;

    state_t      state, state_next;
    logic [63:0] rbuf [8];
    logic [63:0] wbuf [8];
    logic [3:0]  wcnt;
    logic [2:0]  rcnt;
    logic [2:0]  wptr;
    logic        is_write;
    logic [63:0] line_addr;
    logic        accept_rd, accept_wr, push;

    assign accept_rd = (state == IDLE) && req_i && !rw_i;
    assign accept_wr = (state == IDLE) && req_i && rw_i && (wcnt == 4'd8);
    assign push      = (state == IDLE) && fifo_wen_i && (wcnt != 4'd8);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept_rd) state_next = AR;
                    else if (accept_wr) state_next = AW;
            AR:     if (arready_i) state_next = R;
            R:      if (rvalid_i && rcnt == 3'd7) state_next = STREAM;
            STREAM: if (rcnt == 3'd7) state_next = DONE;
            AW:     if (awready_i) state_next = W;
            W:      if (wready_i && wptr == 3'd7) state_next = B;
            B:      if (bvalid_i) state_next = DONE;
            DONE:   if (fifo_done_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // rcnt wraps 7->0 on entering STREAM and is reused as the stream beat index.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt      <= '0;
            rcnt      <= '0;
            wptr      <= '0;
            is_write  <= 1'b0;
            line_addr <= '0;
        end else begin
            if (push) wcnt <= wcnt + 4'd1;
            if (accept_rd || accept_wr) begin
                line_addr <= {addr_i[63:6], 6'b0};
                is_write  <= rw_i;
                rcnt      <= '0;
                wptr      <= '0;
            end
            if ((state == R && rvalid_i) || state == STREAM) rcnt <= rcnt + 3'd1;
            if (state == W && wready_i) wptr <= wptr + 3'd1;
            if (state == DONE && fifo_done_i && is_write) wcnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) wbuf[wcnt[2:0]] <= fifo_data_i;
        if (state == R && rvalid_i) rbuf[rcnt] <= rdata_i;
    end

    always_comb begin
        done_o     = 1'b0;
        data_o     = '0;
        beat_idx_o = '0;
        arvalid_o  = 1'b0;
        rready_o   = 1'b0;
        awvalid_o  = 1'b0;
        wvalid_o   = 1'b0;
        wdata_o    = '0;
        wlast_o    = 1'b0;
        bready_o   = 1'b0;
        araddr_o   = line_addr;
        awaddr_o   = line_addr;
        arlen_o    = 8'd7;
        awlen_o    = 8'd7;
        arsize_o   = 3'd3;
        awsize_o   = 3'd3;
        arburst_o  = 2'b01;
        awburst_o  = 2'b01;
        wstrb_o    = '1;
        case (state)
            AR:     arvalid_o = 1'b1;
            R:      rready_o  = 1'b1;
            STREAM: begin
                done_o     = 1'b1;
                data_o     = rbuf[rcnt];
                beat_idx_o = rcnt;
            end
            AW:     awvalid_o = 1'b1;
            W: begin
                wvalid_o = 1'b1;
                wdata_o  = wbuf[wptr];
                wlast_o  = (wptr == 3'd7);
            end
            B:      bready_o = 1'b1;
            DONE:   done_o   = is_write;
            default: ;
        endcase
    end

`ifdef AXI_CTL_RESP_CHECK_EN
    logic err;
    logic unused_rlast;
    assign unused_rlast = rlast_i;

    always_ff @(posedge clk) begin
        if (rst) err <= 1'b0;
        else if ((state == R && rvalid_i && rresp_i != 2'b00) ||
                 (state == B && bvalid_i && bresp_i != 2'b00))
            err <= 1'b1;
    end
    assign err_o = err;
`else
    logic unused_resp;
    assign unused_resp = ^{rlast_i, rresp_i, bresp_i};
    assign err_o = 1'b0;
`endif

    logic unused_addr;
    assign unused_addr = ^addr_i[5:0];

endmodule

// File: tb/tb_cache_axi_ctl.sv
// Scoreboard bench for cache_axi_ctl: bench-side AXI slave and cache driver, expected beats queued at stimulus time.
module tb_cache_axi_ctl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_i = 1'b0, rw_i = 1'b0;
    logic [63:0] addr_i = '0;
    logic        fifo_wen_i = 1'b0;
    logic [63:0] fifo_data_i = '0;
    logic        fifo_done_i = 1'b0;
    logic        done_o, err_o;
    logic [63:0] data_o;
    logic [2:0]  beat_idx_o;
    logic        arvalid_o, arready_i = 1'b0;
    logic [63:0] araddr_o;
    logic [7:0]  arlen_o;
    logic [2:0]  arsize_o;
    logic [1:0]  arburst_o;
    logic        rvalid_i = 1'b0, rready_o, rlast_i = 1'b0;
    logic [63:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0;
    logic        awvalid_o, awready_i = 1'b0;
    logic [63:0] awaddr_o;
    logic [7:0]  awlen_o;
    logic [2:0]  awsize_o;
    logic [1:0]  awburst_o;
    logic        wvalid_o, wready_i = 1'b0, wlast_o;
    logic [63:0] wdata_o;
    logic [7:0]  wstrb_o;
    logic        bvalid_i = 1'b0, bready_o;
    logic [1:0]  bresp_i = '0;

    int checks = 0;
    int errors = 0;
    logic [63:0] rq[$];
    logic [63:0] wq[$];

    always #5 clk = ~clk;

    cache_axi_ctl dut (
        .clk(clk), .rst(rst), .req_i(req_i), .rw_i(rw_i), .addr_i(addr_i),
        .fifo_wen_i(fifo_wen_i), .fifo_data_i(fifo_data_i), .fifo_done_i(fifo_done_i),
        .done_o(done_o), .data_o(data_o), .beat_idx_o(beat_idx_o), .err_o(err_o),
        .arvalid_o(arvalid_o), .arready_i(arready_i), .araddr_o(araddr_o),
        .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
        .rvalid_i(rvalid_i), .rready_o(rready_o), .rdata_i(rdata_i),
        .rresp_i(rresp_i), .rlast_i(rlast_i),
        .awvalid_o(awvalid_o), .awready_i(awready_i), .awaddr_o(awaddr_o),
        .awlen_o(awlen_o), .awsize_o(awsize_o), .awburst_o(awburst_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .wdata_o(wdata_o),
        .wstrb_o(wstrb_o), .wlast_o(wlast_o),
        .bvalid_i(bvalid_i), .bready_o(bready_o), .bresp_i(bresp_i)
    );

    task automatic push_beats(input int first, input int n, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            fifo_wen_i  = 1'b1;
            fifo_data_i = base * 64'(first + i + 1);
            wq.push_back(fifo_data_i);
        end
        @(negedge clk);
        fifo_wen_i = 1'b0;
    endtask

    task automatic serve_read(input logic [63:0] exp_addr, input int ar_stall,
                              input bit r_gap, input logic [1:0] rresp_v, input bit chk_lat);
        int stall_left = ar_stall;
        int rbeat = 0, sidx = 0, cyc = 0, ar_seen = -1, first_done = -1;
        bit released = 0, fin = 0, ar_pend = 0;
        logic [63:0] exp;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (released) begin
                fifo_done_i = 1'b0;
                fin = 1;
                checks++;
                if ({done_o, arvalid_o, rready_o} !== 3'b000) begin
                    errors++;
                    $display("FAIL read_release: done/arvalid/rready=%b expected 000", {done_o, arvalid_o, rready_o});
                end
            end else begin
                if (ar_pend) begin
                    checks++;
                    if (arvalid_o !== 1'b1) begin
                        errors++;
                        $display("FAIL ar_hold: arvalid_o=%b expected 1", arvalid_o);
                    end
                end
                if (arvalid_o) begin
                    if (ar_seen < 0) ar_seen = cyc;
                    req_i = 1'b0;
                    checks++;
                    if ({araddr_o, arlen_o, arsize_o, arburst_o} !== {exp_addr, 8'd7, 3'd3, 2'b01}) begin
                        errors++;
                        $display("FAIL ar_payload: addr=%h len=%0d size=%0d burst=%b expected addr=%h len=7 size=3 burst=01",
                                 araddr_o, arlen_o, arsize_o, arburst_o, exp_addr);
                    end
                    arready_i = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                    ar_pend = !arready_i;
                end else begin
                    arready_i = 1'b0;
                    ar_pend = 0;
                end
                if (rready_o) begin
                    rvalid_i = !(r_gap && (cyc % 2 == 1));
                    rlast_i  = 1'b0;
                    if (rvalid_i) begin
                        rdata_i = {$urandom, $urandom};
                        rresp_i = rresp_v;
                        rlast_i = (rbeat == 7);
                        rq.push_back(rdata_i);
                        rbeat++;
                    end
                end else begin
                    rvalid_i = 1'b0;
                    rlast_i  = 1'b0;
                end
                if (done_o) begin
                    if (first_done < 0) first_done = cyc;
                    checks++;
                    if (rq.size() == 0) begin
                        errors++;
                        $display("FAIL read_extra_beat: data_o=%h expected no beat", data_o);
                    end else begin
                        exp = rq.pop_front();
                        if (data_o !== exp) begin
                            errors++;
                            $display("FAIL read_data: data_o=%h expected %h", data_o, exp);
                        end
                    end
                    checks++;
                    if (beat_idx_o !== 3'(sidx)) begin
                        errors++;
                        $display("FAIL read_beat_idx: beat_idx_o=%0d expected %0d", beat_idx_o, sidx);
                    end
                    sidx++;
                end else if (sidx >= 8) begin
                    fifo_done_i = 1'b1;
                    released = 1;
                end
            end
        end
        arready_i = 1'b0;
        rvalid_i  = 1'b0;
        rlast_i   = 1'b0;
        rresp_i   = '0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL read_timeout: finished=%0d expected 1", fin);
            fifo_done_i = 1'b0;
        end
        checks++;
        if (sidx != 8 || rq.size() != 0) begin
            errors++;
            $display("FAIL read_count: beats=%0d leftover=%0d expected 8/0", sidx, rq.size());
        end
        if (chk_lat) begin
            checks++;
            if (first_done - ar_seen != 9) begin
                errors++;
                $display("FAIL read_latency: arvalid-to-first-done=%0d cycles expected 9", first_done - ar_seen);
            end
        end
        rq.delete();
    endtask

    task automatic serve_write(input logic [63:0] exp_addr, input int aw_stall,
                               input bit w_toggle, input logic [1:0] bresp_v);
        int stall_left = aw_stall;
        int wbeat = 0, cyc = 0, done_cnt = 0;
        bit released = 0, fin = 0, aw_pend = 0, w_pend = 0, b_hs = 0;
        logic [63:0] prev_wdata = '0, exp;
        logic prev_wlast = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (released) begin
                fifo_done_i = 1'b0;
                fin = 1;
                checks++;
                if ({done_o, awvalid_o, wvalid_o, bready_o} !== 4'b0000) begin
                    errors++;
                    $display("FAIL write_release: done/awvalid/wvalid/bready=%b expected 0000",
                             {done_o, awvalid_o, wvalid_o, bready_o});
                end
            end else begin
                if (b_hs) begin
                    checks++;
                    if (done_o !== 1'b1) begin
                        errors++;
                        $display("FAIL write_done: done_o=%b expected 1", done_o);
                    end
                    done_cnt++;
                    if (done_cnt == 3) begin
                        fifo_done_i = 1'b1;
                        released = 1;
                    end
                end else if (done_o) begin
                    checks++;
                    errors++;
                    $display("FAIL write_early_done: done_o=%b expected 0 before B", done_o);
                end
                if (aw_pend) begin
                    checks++;
                    if (awvalid_o !== 1'b1) begin
                        errors++;
                        $display("FAIL aw_hold: awvalid_o=%b expected 1", awvalid_o);
                    end
                end
                if (awvalid_o) begin
                    req_i = 1'b0;
                    checks++;
                    if ({awaddr_o, awlen_o, awsize_o, awburst_o} !== {exp_addr, 8'd7, 3'd3, 2'b01}) begin
                        errors++;
                        $display("FAIL aw_payload: addr=%h len=%0d size=%0d burst=%b expected addr=%h len=7 size=3 burst=01",
                                 awaddr_o, awlen_o, awsize_o, awburst_o, exp_addr);
                    end
                    awready_i = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                    aw_pend = !awready_i;
                end else begin
                    awready_i = 1'b0;
                    aw_pend = 0;
                end
                if (w_pend) begin
                    checks++;
                    if (wvalid_o !== 1'b1 || wdata_o !== prev_wdata || wlast_o !== prev_wlast) begin
                        errors++;
                        $display("FAIL w_hold: wvalid=%b wdata=%h wlast=%b expected 1 %h %b",
                                 wvalid_o, wdata_o, wlast_o, prev_wdata, prev_wlast);
                    end
                end
                if (wvalid_o) begin
                    wready_i = w_toggle ? (cyc % 2 == 1) : 1'b1;
                    checks++;
                    if (wstrb_o !== 8'hFF) begin
                        errors++;
                        $display("FAIL wstrb: wstrb_o=%h expected ff", wstrb_o);
                    end
                    if (wready_i) begin
                        checks++;
                        if (wq.size() == 0) begin
                            errors++;
                            $display("FAIL w_extra_beat: wdata_o=%h expected no beat", wdata_o);
                        end else begin
                            exp = wq.pop_front();
                            if (wdata_o !== exp) begin
                                errors++;
                                $display("FAIL w_data: wdata_o=%h expected %h", wdata_o, exp);
                            end
                        end
                        checks++;
                        if (wlast_o !== (wbeat == 7)) begin
                            errors++;
                            $display("FAIL w_last: wlast_o=%b on beat %0d expected %b", wlast_o, wbeat, wbeat == 7);
                        end
                        wbeat++;
                    end
                    w_pend = !wready_i;
                    prev_wdata = wdata_o;
                    prev_wlast = wlast_o;
                end else begin
                    wready_i = 1'b0;
                    w_pend = 0;
                end
                if (bready_o) begin
                    bvalid_i = 1'b1;
                    bresp_i  = bresp_v;
                    b_hs = 1;
                end else begin
                    bvalid_i = 1'b0;
                end
            end
        end
        awready_i = 1'b0;
        wready_i  = 1'b0;
        bvalid_i  = 1'b0;
        bresp_i   = '0;
        checks++;
        if (!fin) begin
            errors++;
            $display("FAIL write_timeout: finished=%0d expected 1", fin);
            fifo_done_i = 1'b0;
        end
        checks++;
        if (wbeat != 8 || wq.size() != 0) begin
            errors++;
            $display("FAIL write_count: beats=%0d leftover=%0d expected 8/0", wbeat, wq.size());
        end
        wq.delete();
    endtask

    task automatic expect_no_write_start(input int n, input string tag);
        @(negedge clk);
        req_i  = 1'b1;
        rw_i   = 1'b1;
        addr_i = 64'h0000_0000_8000_3000;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if (awvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL %s: awvalid_o=%b expected 0 (line buffer should be empty)", tag, awvalid_o);
            end
        end
        req_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, done_o, wlast_o, err_o} !== 8'h00) begin
            errors++;
            $display("FAIL reset_ctrl: ar/aw/w/r/b/done/wlast/err=%b expected 00000000",
                     {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, done_o, wlast_o, err_o});
        end
        checks++;
        if ({data_o, beat_idx_o} !== 67'd0 || araddr_o !== 64'd0 || awaddr_o !== 64'd0) begin
            errors++;
            $display("FAIL reset_data: data=%h idx=%0d araddr=%h awaddr=%h expected all 0",
                     data_o, beat_idx_o, araddr_o, awaddr_o);
        end
        rst = 1'b0;
    endtask

    task automatic test_read;
        @(negedge clk);
        req_i = 1'b1; rw_i = 1'b0; addr_i = 64'h0000_0000_8000_1234;
        serve_read(64'h0000_0000_8000_1200, 0, 1'b0, 2'b00, 1'b1);
    endtask

    task automatic test_write_back;
        push_beats(0, 8, 64'h11);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_0000_8000_2040;
        serve_write(64'h0000_0000_8000_2040, 0, 1'b0, 2'b00);
        expect_no_write_start(3, "wb_wcnt_cleared");
    endtask

    task automatic test_backpressure;
        @(negedge clk);
        req_i = 1'b1; rw_i = 1'b0; addr_i = 64'hFFFF_0000_1234_567F;
        serve_read(64'hFFFF_0000_1234_5640, 3, 1'b1, 2'b00, 1'b0);
        push_beats(0, 8, 64'h0102_0304_0506_0708);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_1234_0000_00C5;
        serve_write(64'h0000_1234_0000_00C0, 3, 1'b1, 2'b00);
    endtask

    task automatic test_partial_push;
        logic [63:0] base = 64'h0A0B_0C0D_0000_0001;
        push_beats(0, 5, base);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_0000_4000_0080;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (awvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL partial_idle: awvalid_o=%b expected 0 with 5 beats", awvalid_o);
            end
        end
        for (int i = 5; i < 8; i++) begin
            fifo_wen_i  = 1'b1;
            fifo_data_i = base * 64'(i + 1);
            wq.push_back(fifo_data_i);
            @(negedge clk);
            checks++;
            if (awvalid_o !== 1'b0) begin
                errors++;
                $display("FAIL partial_early: awvalid_o=%b expected 0 after push %0d", awvalid_o, i + 1);
            end
        end
        fifo_wen_i  = 1'b1;
        fifo_data_i = 64'h99;
        @(negedge clk);
        fifo_wen_i = 1'b0;
        checks++;
        if (awvalid_o !== 1'b1) begin
            errors++;
            $display("FAIL partial_start: awvalid_o=%b expected 1 one cycle after 8th push", awvalid_o);
        end
        serve_write(64'h0000_0000_4000_0080, 0, 1'b0, 2'b00);
    endtask

    task automatic test_back_to_back;
        push_beats(0, 3, 64'h5555_0000_0000_0003);
        req_i = 1'b1; rw_i = 1'b0; addr_i = 64'h0000_0000_1000_0000;
        serve_read(64'h0000_0000_1000_0000, 0, 1'b0, 2'b00, 1'b0);
        req_i = 1'b1; rw_i = 1'b0; addr_i = 64'h0000_0000_1000_007F;
        serve_read(64'h0000_0000_1000_0040, 1, 1'b0, 2'b00, 1'b0);
        push_beats(3, 5, 64'h5555_0000_0000_0003);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_0000_2000_0000;
        serve_write(64'h0000_0000_2000_0000, 0, 1'b0, 2'b00);
    endtask

    task automatic test_reset_mid;
        int hs = 0, cyc = 0;
        push_beats(0, 8, 64'h7777);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_0000_6000_0000;
        while (hs < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            awready_i = awvalid_o;
            if (awvalid_o) req_i = 1'b0;
            wready_i = wvalid_o;
            if (wvalid_o) hs++;
        end
        @(negedge clk);
        rst = 1'b1;
        awready_i = 1'b0;
        wready_i = 1'b0;
        req_i = 1'b0;
        @(negedge clk);
        checks++;
        if ({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, done_o, wlast_o} !== 7'b0) begin
            errors++;
            $display("FAIL reset_mid: ar/aw/w/r/b/done/wlast=%b expected 0000000 (w beats seen %0d)",
                     {arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, done_o, wlast_o}, hs);
        end
        rst = 1'b0;
        wq.delete();
        expect_no_write_start(3, "reset_mid_wcnt");
    endtask

    task automatic test_resp_err;
        logic exp_err;
`ifdef AXI_CTL_RESP_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: err_o=%b expected 0 before any error response", err_o);
        end
        push_beats(0, 8, 64'h0F0F);
        req_i = 1'b1; rw_i = 1'b1; addr_i = 64'h0000_0000_7000_0000;
        serve_write(64'h0000_0000_7000_0000, 0, 1'b0, 2'b10);
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL err_after_bresp: err_o=%b expected %b", err_o, exp_err);
        end
        @(negedge clk);
        req_i = 1'b1; rw_i = 1'b0; addr_i = 64'h0000_0000_7000_0040;
        serve_read(64'h0000_0000_7000_0040, 0, 1'b0, 2'b00, 1'b0);
        checks++;
        if (err_o !== exp_err) begin
            errors++;
            $display("FAIL err_sticky: err_o=%b expected %b after clean read", err_o, exp_err);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write_back();
        test_backpressure();
        test_partial_push();
        test_back_to_back();
        test_reset_mid();
        test_resp_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
